// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  // Who owns the response slot in the cycle after a grant.
  typedef enum logic [2:0] {
    OWN_NONE   = 3'd0,
    OWN_IF     = 3'd1,
    OWN_LS_RD  = 3'd2,
    OWN_LS_WR  = 3'd3,
    OWN_LS_ERR = 3'd4
  } resp_owner_t;

  // Streak counter width; covers MAX_LS_STREAK up to 15.
  localparam int STREAK_W = 4;

  // All-ones byte enable source, sliced to the real enable width by users.
  localparam int MAX_BE_W = 64;
  localparam logic [MAX_BE_W-1:0] MEM_BE_ALL = '1;

  // Word alignment check on the low byte-address bits.
  function automatic logic addr_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_streak.sv
// Counts consecutive LS grants while fetch waits and raises the IF override.
module mem_arb_streak
  import mem_arb_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic ls_issue,
  input  logic if_gnt,
  output logic if_override
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  logic [STREAK_W-1:0] streak;

  // Saturating streak: only issued LS accesses while IF waits move it forward.
  always_ff @(posedge clk) begin
    if (reset)
      streak <= '0;
    else if (if_gnt || !if_req)
      streak <= '0;
    else if (ls_issue && streak != STREAK_MAX)
      streak <= streak + 1'b1;
  end

  assign if_override = if_req && (streak == STREAK_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch and load/store.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_BITS = 10,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_if_req,
  input  logic [ADDR_WIDTH-1:0]      i_if_addr,
  output logic                       o_if_ready,
  output logic                       o_if_rvalid,
  output logic [DATA_WIDTH-1:0]      o_if_rdata,
  input  logic                       i_ls_req,
  input  logic                       i_ls_we,
  input  logic [ADDR_WIDTH-1:0]      i_ls_addr,
  input  logic [DATA_WIDTH/8-1:0]    i_ls_be,
  input  logic [DATA_WIDTH-1:0]      i_ls_wdata,
  output logic                       o_ls_ready,
  output logic                       o_ls_rvalid,
  output logic [DATA_WIDTH-1:0]      o_ls_rdata,
  output logic                       o_ls_err,
  output logic                       o_mem_en,
  output logic                       o_mem_we,
  output logic [DATA_WIDTH/8-1:0]    o_mem_be,
  output logic [MEM_ADDR_BITS-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]      o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]      i_mem_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic        if_gnt;
  logic        ls_gnt;
  logic        ls_aligned;
  logic        ls_issue;
  logic        if_override;
  resp_owner_t resp_owner;
  resp_owner_t resp_next;

  // Upper address bits wrap and IF low bits are dropped by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[ADDR_WIDTH-1:MEM_ADDR_BITS+2], i_if_addr[1:0],
                              i_ls_addr[ADDR_WIDTH-1:MEM_ADDR_BITS+2]};

  assign ls_aligned = addr_aligned(i_ls_addr[1:0]);
  assign ls_issue   = ls_gnt && ls_aligned;

  mem_arb_streak #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_streak (
    .clk         (clk),
    .reset       (reset),
    .if_req      (i_if_req),
    .ls_issue    (ls_issue),
    .if_gnt      (if_gnt),
    .if_override (if_override)
  );

  // Grant: LS by default; IF when LS is idle or the streak guard trips.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if (i_ls_req && !if_override)
        ls_gnt = 1'b1;
      else if (i_if_req)
        if_gnt = 1'b1;
    end
  end

  assign o_if_ready = if_gnt;
  assign o_ls_ready = ls_gnt;

  // Memory strobe and payload from the granted requester; misaligned LS is not issued.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_be   = MEM_BE_ALL[BE_W-1:0];
      o_mem_addr = i_if_addr[MEM_ADDR_BITS+1:2];
    end else if (ls_issue) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_be    = i_ls_be;
      o_mem_addr  = i_ls_addr[MEM_ADDR_BITS+1:2];
      o_mem_wdata = i_ls_wdata;
    end
  end

  // Classify this cycle's grant for the response slot.
  always_comb begin
    resp_next = OWN_NONE;
    if (if_gnt)
      resp_next = OWN_IF;
    else if (ls_gnt) begin
      if (!ls_aligned)
        resp_next = OWN_LS_ERR;
      else if (i_ls_we)
        resp_next = OWN_LS_WR;
      else
        resp_next = OWN_LS_RD;
    end
  end

  // Response owner register: one-cycle latency, cleared by reset so in-flight data is dropped.
  always_ff @(posedge clk) begin
    if (reset)
      resp_owner <= OWN_NONE;
    else
      resp_owner <= resp_next;
  end

  // Route the memory read data to the response owner; silent while reset is held.
  always_comb begin
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_ls_rvalid = 1'b0;
    o_ls_rdata  = '0;
    o_ls_err    = 1'b0;
    if (!reset) begin
      case (resp_owner)
        OWN_IF: begin
          o_if_rvalid = 1'b1;
          o_if_rdata  = i_mem_rdata;
        end
        OWN_LS_RD: begin
          o_ls_rvalid = 1'b1;
          o_ls_rdata  = i_mem_rdata;
        end
        OWN_LS_WR: o_ls_rvalid = 1'b1;
        OWN_LS_ERR: begin
          o_ls_rvalid = 1'b1;
          o_ls_err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter with a rule-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int R_NONE = 0, R_IF = 1, R_RD = 2, R_WR = 3, R_ERR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] mem_rdata;

  logic        o_if_ready, o_if_rvalid, o_ls_ready, o_ls_rvalid, o_ls_err;
  logic        o_mem_en, o_mem_we;
  logic [31:0] o_if_rdata, o_ls_rdata, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic [9:0]  o_mem_addr;

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_BITS(10), .MAX_LS_STREAK(MAXS)
  ) dut (
    .clk(clk), .reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(o_if_ready),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_be(ls_be),
    .i_ls_wdata(ls_wdata), .o_ls_ready(o_ls_ready), .o_ls_rvalid(o_ls_rvalid),
    .o_ls_rdata(o_ls_rdata), .o_ls_err(o_ls_err),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Device memory: synchronous read, byte-enabled write, plus a preload port.
  logic [31:0] dev_mem [1024];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge clk) begin
    if (pre_en)
      dev_mem[pre_idx] <= pre_val;
    else if (o_mem_en) begin
      mem_rdata <= dev_mem[o_mem_addr];
      if (o_mem_we)
        for (int b = 0; b < 4; b++)
          if (o_mem_be[b]) dev_mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [1024];
  int          m_streak;
  int          m_resp;
  logic [31:0] m_data;
  string       gseq;

  int total = 0;
  int bad = 0;

  // values captured at the last sample point
  logic        s_if_ready, s_ls_ready, s_mem_en, s_mem_we, s_if_rvalid, s_ls_rvalid, s_ls_err;
  logic [9:0]  s_mem_addr;
  logic [31:0] s_if_rdata, s_ls_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, compare with the model, advance the model, return after posedge.
  task automatic cyc();
    bit ovr, ls_win, if_win, ls_al, ls_rsp;
    int ii, li;
    @(negedge clk);
    s_if_ready = o_if_ready;  s_ls_ready = o_ls_ready;
    s_mem_en = o_mem_en;      s_mem_we = o_mem_we;   s_mem_addr = o_mem_addr;
    s_if_rvalid = o_if_rvalid; s_ls_rvalid = o_ls_rvalid; s_ls_err = o_ls_err;
    s_if_rdata = o_if_rdata;  s_ls_rdata = o_ls_rdata;

    ls_rsp = !rst && (m_resp == R_RD || m_resp == R_WR || m_resp == R_ERR);
    chk("if_rvalid", 64'(o_if_rvalid), 64'(!rst && m_resp == R_IF));
    chk("ls_rvalid", 64'(o_ls_rvalid), 64'(ls_rsp));
    if (!rst && m_resp == R_IF) chk("if_rdata", 64'(o_if_rdata), 64'(m_data));
    if (ls_rsp) begin
      chk("ls_err", 64'(o_ls_err), 64'(m_resp == R_ERR));
      chk("ls_rdata", 64'(o_ls_rdata), (m_resp == R_RD) ? 64'(m_data) : 64'd0);
    end

    ovr    = if_req && (m_streak == MAXS);
    ls_win = !rst && ls_req && !ovr;
    if_win = !rst && if_req && !ls_win;
    ls_al  = (ls_addr % 4) == 0;
    ii     = int'((if_addr / 4) % 1024);
    li     = int'((ls_addr / 4) % 1024);
    chk("if_ready", 64'(o_if_ready), 64'(if_win));
    chk("ls_ready", 64'(o_ls_ready), 64'(ls_win));
    chk("mem_en", 64'(o_mem_en), 64'(if_win || (ls_win && ls_al)));
    if (if_win) begin
      chk("if_mem_addr", 64'(o_mem_addr), 64'(ii));
      chk("if_mem_we", 64'(o_mem_we), 64'd0);
      chk("if_mem_be", 64'(o_mem_be), 64'hF);
    end else if (ls_win && ls_al) begin
      chk("ls_mem_addr", 64'(o_mem_addr), 64'(li));
      chk("ls_mem_we", 64'(o_mem_we), 64'(ls_we));
      if (ls_we) begin
        chk("ls_mem_be", 64'(o_mem_be), 64'(ls_be));
        chk("ls_mem_wdata", 64'(o_mem_wdata), 64'(ls_wdata));
      end
    end

    gseq = {gseq, if_win ? "I" : (ls_win ? "L" : "-")};
    if (rst) begin
      m_streak = 0;
      m_resp   = R_NONE;
    end else begin
      m_resp = R_NONE;
      if (if_win) begin
        m_resp = R_IF;
        m_data = ref_mem[ii];
      end else if (ls_win) begin
        if (!ls_al) m_resp = R_ERR;
        else if (ls_we) begin
          m_resp = R_WR;
          for (int b = 0; b < 4; b++)
            if (ls_be[b]) ref_mem[li][8*b +: 8] = ls_wdata[8*b +: 8];
        end else begin
          m_resp = R_RD;
          m_data = ref_mem[li];
        end
      end
      if (if_win || !if_req) m_streak = 0;
      else if (ls_win && ls_al && m_streak < MAXS) m_streak++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    m_streak = 0;
    m_resp   = R_NONE;
    m_data   = '0;
    gseq     = "";

    // preload memory while held in reset
    pre_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      v = (i == 4) ? 32'h0031_00B3 : $urandom;
      ref_mem[i] = v;
      pre_idx = 10'(i);
      pre_val = v;
      @(posedge clk);
      #1;
    end
    pre_en = 1'b0;

    // 1: reset with both requesting
    if_req = 1'b1; if_addr = 32'h0000_0040;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200; ls_be = 4'hF;
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_if_ready", 64'(s_if_ready), 64'd0);
    chk("rst_mem_en", 64'(s_mem_en), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rel_ls_grant", 64'(s_ls_ready), 64'd1);
    chk("rel_rvalid_none", 64'(s_if_rvalid | s_ls_rvalid), 64'd0);
    if_req = 1'b0; ls_req = 1'b0;
    cyc();

    // 2: fetch only
    if_req = 1'b1; if_addr = 32'h0000_0010;
    cyc();
    chk("if_ready_t2", 64'(s_if_ready), 64'd1);
    chk("if_addr_t2", 64'(s_mem_addr), 64'd4);
    if_req = 1'b0;
    cyc();
    chk("if_rvalid_t2", 64'(s_if_rvalid), 64'd1);
    chk("if_rdata_t2", 64'(s_if_rdata), 64'h0031_00B3);

    // 3: store then load
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_be = 4'hF; ls_wdata = 32'hDEAD_BEEF;
    cyc();
    chk("st_we", 64'(s_mem_we), 64'd1);
    chk("st_addr", 64'(s_mem_addr), 64'h40);
    ls_we = 1'b0; ls_wdata = '0;
    cyc();
    chk("ld_we", 64'(s_mem_we), 64'd0);
    chk("ld_addr", 64'(s_mem_addr), 64'h40);
    chk("st_ack_rdata", 64'(s_ls_rdata), 64'd0);
    ls_req = 1'b0;
    cyc();
    chk("ld_rdata", 64'(s_ls_rdata), 64'hDEAD_BEEF);

    // 4: continuous contention
    gseq = "";
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (s_ls_ready) ls_addr = ls_addr + 32'h4;
      if (s_if_ready) if_addr = if_addr + 32'h4;
    end
    chk("grant_seq", 64'(gseq == "LLLLILLLLI"), 64'd1);
    if_req = 1'b0; ls_req = 1'b0;
    cyc();

    // 5: misaligned load
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h102;
    cyc();
    chk("mis_ready", 64'(s_ls_ready), 64'd1);
    chk("mis_mem_en", 64'(s_mem_en), 64'd0);
    ls_req = 1'b0;
    cyc();
    chk("mis_rvalid", 64'(s_ls_rvalid), 64'd1);
    chk("mis_err", 64'(s_ls_err), 64'd1);
    chk("mis_rdata", 64'(s_ls_rdata), 64'd0);

    // 6: reset right after an LS load grant
    ls_req = 1'b1; ls_addr = 32'h104;
    cyc();
    ls_req = 1'b0; rst = 1'b1;
    cyc();
    chk("rst_drop_0", 64'(s_ls_rvalid), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_drop_n", 64'(s_ls_rvalid), 64'd0);
    end

    // 7: random traffic, payload held until accepted
    for (int k = 0; k < 400; k++) begin
      if (!if_req || s_if_ready) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                  | 32'($urandom_range(0, 3));
      end
      if (!ls_req || s_ls_ready) begin
        ls_req   = ($urandom_range(0, 3) != 0);
        ls_we    = $urandom_range(0, 1) != 0;
        ls_be    = 4'($urandom_range(0, 15));
        ls_wdata = $urandom;
        ls_addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                   | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      end
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      cyc();
      rst = 1'b0;
      s_if_ready = s_if_ready & if_req;
      s_ls_ready = s_ls_ready & ls_req;
    end
    if_req = 1'b0; ls_req = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
